usb_tx_encoder: RTL and testbench
=================================

# usb_tx_encoder

USB 1.1 full-speed transmit line encoder. It takes packet bytes from the TX protocol controller through a one-byte holding register and emits SYNC, the data bits LSB-first with bit stuffing, NRZI encoding and EOP on the D+/D− outputs. Bit timing comes from the downstream-owned `flex_counter_tx` instance: this block drives that counter's enable and clear, and consumes its `rollover_flag` as the per-bit strobe.

## Interface
- `SYNC_PATTERN`, default 8'h80: SYNC byte, sent LSB-first.
- `STUFF_LIMIT`, default 6: number of consecutive 1 bits that forces a stuffed 0.
- `clk` input 1: system clock.
- `n_rst` input 1: reset. One clock; reset is synchronous and active-low.
- `bit_strobe` input 1: one-cycle pulse per bit period, from `flex_counter_tx.rollover_flag`.
- `timer_en` output 1: drives counter `count_enable`.
- `timer_clear` output 1: drives counter `clear`.
- `tx_start` input 1: begins a packet when sampled in IDLE; ignored otherwise.
- `tx_data` input 8: byte to transmit.
- `tx_last` input 1: marks `tx_data` as the final byte; captured together with the byte.
- `tx_valid` input 1: producer has a byte.
- `tx_ready` output 1: holding register is empty. A byte transfers when `tx_valid && tx_ready` at a clock edge.
- `dp_out`, `dm_out` output 1 each: line state. J = 1/0, K = 0/1, SE0 = 0/0.
- `tx_busy` output 1: high in every state except IDLE.
- `tx_done` output 1: one-cycle pulse on normal packet completion.
- `tx_error` output 1: one-cycle pulse on completion of an aborted (underrun) packet.

## Operation
- States: IDLE, SYNC, DATA, STUFF, EOP_SE0A, EOP_SE0B, EOP_J.
- IDLE: line is J.
  - When `tx_start` is sampled, go to SYNC, pulse `timer_clear` for one cycle, and set `timer_en` = 1 until the return to IDLE.
- SYNC: sends 8 `SYNC_PATTERN` bits, one per strobe.
- Holding register:
  - Loaded on a handshake. The producer may preload it in IDLE.
  - When the shifter needs a byte (the last SYNC bit or bit 7 of the current byte is being sent), the holding register is copied into the shifter on that strobe edge.
  - `tx_ready` is low while the register is full. There is no write-through, so a write and a load never collide.
- Underrun: a byte is needed, the holding register is empty, and the last byte has not been sent.
  - Go to EOP_SE0A and set an abort flag.
- After a byte loaded with `tx_last` is fully sent, with any stuff bit pending, go to EOP_SE0A.
- NRZI: a 0 bit toggles J↔K; a 1 bit holds the line.
- Stuffing:
  - A 3-bit ones counter increments on each 1 bit sent, including SYNC bits. It clears on a 0 bit or a stuffed bit.
  - When it reaches `STUFF_LIMIT`, the next strobe goes to STUFF. STUFF sends a 0 (toggle) and does not advance the data index.
  - Stuffing also applies after the final data bit, before EOP.
- EOP: SE0 for two bit periods, then J for one bit period, then IDLE.
  - On the edge leaving EOP_J: pulse `tx_done`, or `tx_error` if the abort flag is set; clear the abort flag.
- Reset (any time, including mid-packet):
  - State returns to IDLE, holding register is emptied, ones counter and abort flag clear.
  - Output values: `dp_out`=1, `dm_out`=0, `tx_busy`=0, `timer_en`=0, `timer_clear`=0, `tx_done`=0, `tx_error`=0, `tx_ready`=1.

## Timing
- All outputs are registered except `tx_ready`, which is the inverse of the holding-full flag.
- The line changes on the clock edge where `bit_strobe` is sampled high: 1-cycle latency from strobe to new line state.
- `bit_strobe` is ignored in IDLE.
- The first strobe after start puts SYNC bit 0 (K) on the line.
- The holding register frees on the cycle after a shifter load, so `tx_ready` rises one clock after that strobe edge.
- Packet length in strobes: 8 (SYNC) + 8·bytes + stuff bits + 3 (EOP).

## Structure
- Package `usb_tx_pkg`:
  - state enum
  - line-state constants J/K/SE0
  - `SYNC_PATTERN` and `STUFF_LIMIT` defaults
- Sub-module `usb_tx_bit_stuffer`: ones counter, stuff-request output, and NRZI toggle register. It is advanced by strobe, bit value and stuff-taken.
- Top level holds the FSM, holding register, shifter and bit index.

## Test plan
- Reset then idle strobes → `dp_out`/`dm_out` = 1/0, `tx_ready`=1, `tx_busy`=0, line unchanged.
- Start, then byte 8'h00 with `tx_last` → line K J K J K J K K | J K J K J K J K | SE0 SE0 J.
  - 19 strobes; `tx_done` pulses once; `tx_error` stays 0.
- Byte 8'hFF with `tx_last` → 5 data bits held at K, stuffed toggle to J, 3 bits held at J, then EOP.
  - 20 strobes total (SYNC's trailing 1 counts toward the limit).
- Byte 8'hFC with `tx_last` → six trailing ones are followed by a stuffed 0 before SE0.
  - 20 strobes total.
- Start with no byte written → SYNC, then SE0 SE0 J; `tx_error` pulses; `tx_done` stays 0.
- Bytes 8'hA5, 8'h5A, 8'hC3 (last), with `tx_valid` held high:
  - `tx_ready` drops after each write and rises one clock after each load.
  - No byte is lost or duplicated.
- Reassert `n_rst` low mid-packet → J line and IDLE on the next clock edge.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared types and constants for the USB full-speed TX encoder
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_STUFF,
    ST_EOP_SE0A,
    ST_EOP_SE0B,
    ST_EOP_J
  } tx_state_t;

  // Line states as {dp, dm}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [7:0] SYNC_PATTERN_DEF = 8'h80;
  localparam int         STUFF_LIMIT_DEF  = 6;

endpackage

// File: rtl/usb_tx_bit_stuffer.sv
// rtl/usb_tx_bit_stuffer.sv - consecutive-ones counter and NRZI line level tracker
module usb_tx_bit_stuffer
  import usb_tx_pkg::*;
#(
  parameter int STUFF_LIMIT = STUFF_LIMIT_DEF
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic strobe,
  input  logic bit_val,
  input  logic stuff_taken,
  output logic stuff_req,
  output logic line_j,
  output logic line_j_next
);

  logic [2:0] ones_cnt;
  logic       one_sent;

  assign one_sent    = bit_val && !stuff_taken;
  // Asserted while the bit being sent is the one that reaches the limit
  assign stuff_req   = one_sent && (ones_cnt == 3'(STUFF_LIMIT - 1));
  assign line_j_next = one_sent ? line_j : !line_j;

  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      ones_cnt <= 3'd0;
      line_j   <= 1'b1;
    end else if (strobe) begin
      line_j   <= line_j_next;
      ones_cnt <= one_sent ? ones_cnt + 3'd1 : 3'd0;
    end
  end

endmodule

// File: rtl/usb_tx_encoder.sv
// rtl/usb_tx_encoder.sv - USB 1.1 full-speed TX line encoder: SYNC, stuffed NRZI data, EOP
module usb_tx_encoder
  import usb_tx_pkg::*;
#(
  parameter logic [7:0] SYNC_PATTERN = SYNC_PATTERN_DEF,
  parameter int         STUFF_LIMIT  = STUFF_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       bit_strobe,
  output logic       timer_en,
  output logic       timer_clear,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       dp_out,
  output logic       dm_out,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  tx_state_t  state, state_n;
  logic       hold_full, hold_last, cur_last, abort_q, eop_pend;
  logic [7:0] hold_data, shift_q;
  logic [2:0] bit_idx;
  logic [1:0] line_q;
  logic       adv, cur_bit, need_byte, load, underrun;
  logic       stuff_req, line_j, line_j_next;

  assign adv       = bit_strobe && (state inside {ST_SYNC, ST_DATA, ST_STUFF});
  assign need_byte = bit_strobe && (bit_idx == 3'd7) &&
                     (state == ST_SYNC || (state == ST_DATA && !cur_last));
  assign load      = need_byte && hold_full;
  assign underrun  = need_byte && !hold_full;
  assign tx_ready  = !hold_full;
  assign {dp_out, dm_out} = line_q;

  always_comb begin
    cur_bit = 1'b0;
    case (state)
      ST_SYNC: cur_bit = SYNC_PATTERN[bit_idx];
      ST_DATA: cur_bit = shift_q[bit_idx];
      default: cur_bit = 1'b0;
    endcase
  end

  usb_tx_bit_stuffer #(.STUFF_LIMIT(STUFF_LIMIT)) u_stuffer (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (state == ST_IDLE),
    .strobe     (adv),
    .bit_val    (cur_bit),
    .stuff_taken(state == ST_STUFF),
    .stuff_req  (stuff_req),
    .line_j     (line_j),
    .line_j_next(line_j_next)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (tx_start) state_n = ST_SYNC;
      ST_SYNC:
        if (underrun)                         state_n = ST_EOP_SE0A;
        else if (bit_strobe && bit_idx == 3'd7) state_n = stuff_req ? ST_STUFF : ST_DATA;
      ST_DATA:
        if (bit_strobe) begin
          if (underrun)                             state_n = ST_EOP_SE0A;
          else if (bit_idx == 3'd7 && cur_last)     state_n = stuff_req ? ST_STUFF : ST_EOP_SE0A;
          else if (stuff_req)                       state_n = ST_STUFF;
        end
      ST_STUFF:    if (bit_strobe) state_n = eop_pend ? ST_EOP_SE0A : ST_DATA;
      ST_EOP_SE0A: if (bit_strobe) state_n = ST_EOP_SE0B;
      ST_EOP_SE0B: if (bit_strobe) state_n = ST_EOP_J;
      ST_EOP_J:    if (bit_strobe) state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state       <= ST_IDLE;
      hold_full   <= 1'b0;
      hold_data   <= 8'd0;
      hold_last   <= 1'b0;
      shift_q     <= 8'd0;
      cur_last    <= 1'b0;
      bit_idx     <= 3'd0;
      abort_q     <= 1'b0;
      eop_pend    <= 1'b0;
      line_q      <= LINE_J;
      timer_en    <= 1'b0;
      timer_clear <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      state       <= state_n;
      timer_clear <= (state == ST_IDLE) && tx_start;
      timer_en    <= (state_n != ST_IDLE);
      tx_busy     <= (state_n != ST_IDLE);
      tx_done     <= (state == ST_EOP_J) && bit_strobe && !abort_q;
      tx_error    <= (state == ST_EOP_J) && bit_strobe && abort_q;

      // No write-through: a load needs a full register, a write an empty one
      if (load) begin
        hold_full <= 1'b0;
        shift_q   <= hold_data;
        cur_last  <= hold_last;
      end else if (tx_valid && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
        hold_last <= tx_last;
      end

      if (adv && state != ST_STUFF) bit_idx <= bit_idx + 3'd1;
      if (bit_strobe && state == ST_DATA && bit_idx == 3'd7 && cur_last) eop_pend <= 1'b1;
      if (underrun) abort_q <= 1'b1;
      if (state == ST_EOP_J && bit_strobe) abort_q <= 1'b0;
      if (state == ST_IDLE) begin
        bit_idx  <= 3'd0;
        eop_pend <= 1'b0;
        cur_last <= 1'b0;
      end

      if (adv)
        line_q <= line_j_next ? LINE_J : LINE_K;
      else if (bit_strobe && (state == ST_EOP_SE0A || state == ST_EOP_SE0B))
        line_q <= LINE_SE0;
      else if (bit_strobe && state == ST_EOP_J)
        line_q <= LINE_J;
    end
  end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb/tb_usb_tx_encoder.sv - randomized self-checking bench for usb_tx_encoder
module tb_usb_tx_encoder;

  logic       clk = 1'b0;
  logic       n_rst, bit_strobe, tx_start, tx_valid, tx_last;
  logic [7:0] tx_data;
  logic       timer_en, timer_clear, tx_ready, dp_out, dm_out, tx_busy, tx_done, tx_error;
  int         n_vec = 0;
  int         n_miss = 0;
  logic [1:0] exp_line[$];
  bit         exp_load[$];

  always #5 clk = ~clk;

  usb_tx_encoder dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .bit_strobe (bit_strobe),
    .timer_en   (timer_en),
    .timer_clear(timer_clear),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .dp_out     (dp_out),
    .dm_out     (dm_out),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line state per strobe: bit list -> stuffing -> NRZI -> EOP
  task automatic build_model(input logic [7:0] pkt[$]);
    logic [7:0] b;
    int         ones = 0;
    logic       lvl = 1'b1;
    exp_line.delete();
    exp_load.delete();
    for (int i = -1; i < pkt.size(); i++) begin
      b = (i < 0) ? 8'h80 : pkt[i];
      for (int j = 0; j < 8; j++) begin
        if (b[j]) ones++;
        else begin lvl = !lvl; ones = 0; end
        exp_line.push_back(lvl ? 2'b10 : 2'b01);
        exp_load.push_back(j == 7 && (i + 1) < pkt.size());
        if (ones == 6) begin
          lvl = !lvl;
          ones = 0;
          exp_line.push_back(lvl ? 2'b10 : 2'b01);
          exp_load.push_back(1'b0);
        end
      end
    end
    exp_line.push_back(2'b00); exp_load.push_back(1'b0);
    exp_line.push_back(2'b00); exp_load.push_back(1'b0);
    exp_line.push_back(2'b10); exp_load.push_back(1'b0);
  endtask

  task automatic run_packet(input string name, input logic [7:0] pkt[$], input int exp_len,
                            input bit exp_err, input int abort_at);
    int k = 0, nb = 0, cyc = 0, gap, done_n = 0, err_n = 0, done_at = -1;
    bit xfer, stb;
    build_model(pkt);
    if (exp_len < 0) exp_len = exp_line.size();
    @(negedge clk);
    tx_start   = 1'b1;
    bit_strobe = 1'b0;
    tx_valid   = (pkt.size() > 0);
    tx_data    = (pkt.size() > 0) ? pkt[0] : 8'h00;
    tx_last    = (pkt.size() == 1);
    gap = $urandom_range(2, 5);
    while (cyc < 3000) begin
      xfer = tx_valid && tx_ready;
      stb  = bit_strobe;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check({name, "_timer_clear"}, timer_clear, 1);
        check({name, "_timer_en"}, timer_en, 1);
        check({name, "_busy"}, tx_busy, 1);
      end else if (cyc == 2) begin
        check({name, "_timer_clear_pulse"}, timer_clear, 0);
      end
      if (xfer) begin
        check({name, "_ready_drop"}, tx_ready, 0);
        nb++;
      end
      if (stb) begin
        check({name, "_line"}, {dp_out, dm_out}, exp_line[k]);
        if (exp_load[k]) check({name, "_ready_rise"}, tx_ready, 1);
        k++;
      end
      if (tx_done)  begin done_n++; done_at = k; end
      if (tx_error) begin err_n++;  done_at = k; end
      if (k == exp_line.size()) break;
      if (abort_at >= 0 && k == abort_at) begin
        n_rst = 1'b0; bit_strobe = 1'b0; tx_valid = 1'b0; tx_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({name, "_rst_line"}, {dp_out, dm_out}, 2'b10);
        check({name, "_rst_busy"}, tx_busy, 0);
        check({name, "_rst_ready"}, tx_ready, 1);
        check({name, "_rst_timer_en"}, timer_en, 0);
        n_rst = 1'b1;
        return;
      end
      tx_start = 1'b0;
      tx_valid = (nb < pkt.size());
      if (tx_valid) begin
        tx_data = pkt[nb];
        tx_last = (nb == pkt.size() - 1);
      end
      gap--;
      bit_strobe = (gap == 0);
      if (gap == 0) gap = $urandom_range(2, 5);
    end
    bit_strobe = 1'b0;
    tx_valid   = 1'b0;
    tx_start   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (tx_done) done_n++;
    if (tx_error) err_n++;
    check({name, "_len"}, done_at, exp_len);
    check({name, "_done_cnt"}, done_n, exp_err ? 0 : 1);
    check({name, "_err_cnt"}, err_n, exp_err ? 1 : 0);
    check({name, "_idle_busy"}, tx_busy, 0);
    check({name, "_idle_line"}, {dp_out, dm_out}, 2'b10);
  endtask

  initial begin
    logic [7:0] q[$];
    n_rst = 1'b0; bit_strobe = 1'b0; tx_start = 1'b0;
    tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_line", {dp_out, dm_out}, 2'b10);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_timer_en", timer_en, 0);
    check("rst_timer_clear", timer_clear, 0);
    check("rst_done_err", {tx_done, tx_error}, 2'b00);
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bit_strobe = 1'b1;
      @(negedge clk);
      bit_strobe = 1'b0;
      @(negedge clk);
      check("idle_line", {dp_out, dm_out}, 2'b10);
      check("idle_busy", tx_busy, 0);
    end

    q = {8'h00};               run_packet("byte00", q, 19, 0, -1);
    q = {8'hFF};               run_packet("byteFF", q, 20, 0, -1);
    q = {8'hFC};               run_packet("byteFC", q, 20, 0, -1);
    q.delete();                run_packet("underrun", q, 11, 1, -1);
    q = {8'hA5, 8'h5A, 8'hC3}; run_packet("three", q, 35, 0, -1);

    for (int p = 0; p < 8; p++) begin
      q.delete();
      for (int i = 0; i < $urandom_range(1, 6); i++) q.push_back(8'($urandom));
      run_packet($sformatf("rand%0d", p), q, -1, 0, -1);
    end

    q = {8'h3C, 8'h99};        run_packet("midrst", q, -1, 0, 12);
    q = {8'h7E, 8'hFF};        run_packet("after_rst", q, -1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
